write_frame_ddr: RTL



---
 rtl/write_frame_ddr_if.sv | 19 +
 rtl/write_frame_ddr.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/write_frame_ddr_if.sv
// Avalon-MM burst write bus between the frame writer (master) and the f2h_sdram port (slave).
interface write_frame_ddr_if;
   logic        avm_write;
   logic [29:0] avm_address;
   logic [7:0]  avm_burstcount;
   logic [31:0] avm_writedata;
   logic [3:0]  avm_byteenable;
   logic        avm_waitrequest;

   modport master (
      output avm_write, avm_address, avm_burstcount, avm_writedata, avm_byteenable,
      input  avm_waitrequest
   );

   modport slave (
      input  avm_write, avm_address, avm_burstcount, avm_writedata, avm_byteenable,
      output avm_waitrequest
   );
endinterface

// File: rtl/write_frame_ddr.sv
// Buffers an RGB888 pixel stream in a FIFO and writes it to the DDR frame buffer
// as fixed-length Avalon bursts; pulses frame_done after the last burst of a frame.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no frame active, waiting for sof
// WAIT_DATA | frame active, waiting for a full burst of pixels
// BURST     | presenting burst beats, holding on waitrequest
// LAST      | final burst done, frame_done asserted, returning to IDLE
module write_frame_ddr #(
   parameter int BURST_LEN       = 80,
   parameter int BURSTS_PER_LINE = 16,
   parameter int LINES           = 720,
   parameter int FIFO_DEPTH      = 256
) (
   input  logic              clk_100,
   input  logic              reset_b,
   input  logic              sof,
   input  logic [29:0]       addr_write_ddr,
   input  logic              valid_rgb,
   input  logic [7:0]        r_data,
   input  logic [7:0]        g_data,
   input  logic [7:0]        b_data,
   output logic              frame_done,
   output logic              overflow,
   write_frame_ddr_if.master avm
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(BURST_LEN);
   localparam logic [13:0] LAST_BURST = 14'(LINES * BURSTS_PER_LINE - 1);

   typedef enum logic [1:0] {IDLE, WAIT_DATA, BURST, LAST} state_t;

   state_t      state_q, state_d;
   logic        active_q, active_d;
   logic        overflow_q, overflow_d;
   logic        frame_done_q, frame_done_d;
   logic        avm_write_q, avm_write_d;
   logic [29:0] avm_address_q, avm_address_d;
   logic [31:0] avm_writedata_q, avm_writedata_d;
   logic [29:0] next_addr_q, next_addr_d;
   logic [13:0] burst_cnt_q, burst_cnt_d;
   logic [BW-1:0] beat_cnt_q, beat_cnt_d;
   logic        sof_pend_q, sof_pend_d;
   logic [29:0] base_pend_q, base_pend_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic [23:0] fifo_mem [FIFO_DEPTH];
   logic [23:0] fifo_head, fifo_next;
   logic [AW-1:0] wr_addr;
   logic        accept, full, push, pop, flush, keep_pix, restart, ovf_set;
   logic [29:0] restart_base;

   assign accept    = avm_write_q & ~avm.avm_waitrequest;
   assign full      = (count_q == CW'(FIFO_DEPTH));
   assign fifo_head = fifo_mem[rd_ptr_q];
   assign fifo_next = fifo_mem[rd_ptr_q + AW'(1)];
   assign wr_addr   = flush ? '0 : wr_ptr_q;

   always_comb begin
      state_d         = state_q;
      active_d        = active_q;
      overflow_d      = overflow_q;
      frame_done_d    = 1'b0;
      avm_write_d     = avm_write_q;
      avm_address_d   = avm_address_q;
      avm_writedata_d = avm_writedata_q;
      next_addr_d     = next_addr_q;
      burst_cnt_d     = burst_cnt_q;
      beat_cnt_d      = beat_cnt_q;
      sof_pend_d      = sof_pend_q;
      base_pend_d     = base_pend_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      count_d         = count_q;
      pop             = 1'b0;
      restart         = 1'b0;
      restart_base    = addr_write_ddr;

      case (state_q)
         IDLE: restart = sof;
         WAIT_DATA: begin
            if (sof) begin
               restart = 1'b1;
            end else if (count_q >= CW'(BURST_LEN)) begin
               state_d         = BURST;
               avm_write_d     = 1'b1;
               avm_address_d   = next_addr_q;
               avm_writedata_d = {8'h00, fifo_head};
               beat_cnt_d      = '0;
            end
         end
         BURST: begin
            // a started burst must finish; sof is remembered until the last beat
            if (sof) begin
               sof_pend_d  = 1'b1;
               base_pend_d = addr_write_ddr;
            end
            if (accept) begin
               pop = 1'b1;
               if (beat_cnt_q == BW'(BURST_LEN - 1)) begin
                  avm_write_d = 1'b0;
                  burst_cnt_d = burst_cnt_q + 14'd1;
                  next_addr_d = next_addr_q + 30'(BURST_LEN);
                  if (sof || sof_pend_q) begin
                     restart      = 1'b1;
                     restart_base = sof ? addr_write_ddr : base_pend_q;
                  end else if (burst_cnt_q == LAST_BURST) begin
                     state_d      = LAST;
                     frame_done_d = 1'b1;
                  end else begin
                     state_d = WAIT_DATA;
                  end
               end else begin
                  beat_cnt_d      = beat_cnt_q + BW'(1);
                  avm_writedata_d = {8'h00, fifo_next};
               end
            end
         end
         LAST: begin
            active_d = 1'b0;
            state_d  = IDLE;
            restart  = sof;
         end
         default: state_d = IDLE;
      endcase

      // outside a burst the sof-cycle pixel opens the new frame; after a
      // deferred restart the flush cycle discards whatever arrives with it
      keep_pix = (state_q != BURST);
      flush    = restart;
      if (restart) begin
         state_d     = WAIT_DATA;
         active_d    = 1'b1;
         next_addr_d = restart_base;
         burst_cnt_d = '0;
         sof_pend_d  = 1'b0;
      end

      push    = valid_rgb & (active_q | restart) & (flush ? keep_pix : ~full);
      ovf_set = valid_rgb & active_q & ~flush & full;
      if (sof) begin
         overflow_d = 1'b0;
      end else if (ovf_set) begin
         overflow_d = 1'b1;
      end

      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = push ? AW'(1) : '0;
         count_d  = push ? CW'(1) : '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push && !pop) begin
            count_d = count_q + CW'(1);
         end else if (pop && !push) begin
            count_d = count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk_100 or negedge reset_b) begin
      if (!reset_b) begin
         state_q         <= IDLE;
         active_q        <= 1'b0;
         overflow_q      <= 1'b0;
         frame_done_q    <= 1'b0;
         avm_write_q     <= 1'b0;
         avm_address_q   <= '0;
         avm_writedata_q <= '0;
         next_addr_q     <= '0;
         burst_cnt_q     <= '0;
         beat_cnt_q      <= '0;
         sof_pend_q      <= 1'b0;
         base_pend_q     <= '0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
      end else begin
         state_q         <= state_d;
         active_q        <= active_d;
         overflow_q      <= overflow_d;
         frame_done_q    <= frame_done_d;
         avm_write_q     <= avm_write_d;
         avm_address_q   <= avm_address_d;
         avm_writedata_q <= avm_writedata_d;
         next_addr_q     <= next_addr_d;
         burst_cnt_q     <= burst_cnt_d;
         beat_cnt_q      <= beat_cnt_d;
         sof_pend_q      <= sof_pend_d;
         base_pend_q     <= base_pend_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
      end
   end

   always_ff @(posedge clk_100) begin
      if (push) fifo_mem[wr_addr] <= {b_data, g_data, r_data};
   end

   assign frame_done         = frame_done_q;
   assign overflow           = overflow_q;
   assign avm.avm_write      = avm_write_q;
   assign avm.avm_address    = avm_address_q;
   assign avm.avm_writedata  = avm_writedata_q;
   assign avm.avm_burstcount = 8'(BURST_LEN);
   assign avm.avm_byteenable = 4'hF;
endmodule
